// File: rtl/palette_color_encoder.sv
// Nearest-palette-colour encoder: scans the 16-entry sprite palette one entry
// per cycle and reports the lowest-index entry at minimum Manhattan distance.
module palette_color_encoder #(
    parameter logic [11:0] KEY_COLOR         = 12'hE3F,
    parameter logic [3:0]  TRANSPARENT_INDEX = 4'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [5:0]  out_dist,
    output logic        out_transparent
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [11:0] rgb_q;
    logic [5:0]  best_dist_q, best_dist_d;
    logic [3:0]  best_idx_q, best_idx_d;
    logic        out_valid_q;
    logic [3:0]  out_index_q;
    logic [5:0]  out_dist_q;
    logic        out_transparent_q;
    logic [11:0] entry_rgb;
    logic [5:0]  entry_dist;

    function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'd1:    c = 12'h222;
            4'd2:    c = 12'h7A7;
            4'd5:    c = 12'h000;
            4'd6:    c = 12'h464;
            4'd7:    c = 12'h110;
            4'd9:    c = 12'h343;
            4'd10:   c = 12'h686;
            4'd13:   c = 12'h575;
            4'd14:   c = 12'h111;
            default: c = KEY_COLOR;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] diff;
        logic signed [4:0] neg;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        neg  = -diff;
        return diff[4] ? neg[3:0] : diff[3:0];
    endfunction

    function automatic logic [5:0] color_dist(input logic [11:0] a, input logic [11:0] b);
        return {2'b00, abs_diff(a[11:8], b[11:8])}
             + {2'b00, abs_diff(a[7:4],  b[7:4])}
             + {2'b00, abs_diff(a[3:0],  b[3:0])};
    endfunction

    // Key-coloured entries still take their cycle so latency never varies.
    always_comb begin
        entry_rgb   = palette_rgb(cnt_q);
        entry_dist  = color_dist(rgb_q, entry_rgb);
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        if ((entry_rgb != KEY_COLOR) && (entry_dist < best_dist_q)) begin
            best_dist_d = entry_dist;
            best_idx_d  = cnt_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q           <= IDLE;
            cnt_q             <= 4'd0;
            rgb_q             <= 12'd0;
            best_dist_q       <= 6'd0;
            best_idx_q        <= 4'd0;
            out_valid_q       <= 1'b0;
            out_index_q       <= 4'd0;
            out_dist_q        <= 6'd0;
            out_transparent_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rgb_q       <= in_rgb;
                        cnt_q       <= 4'd0;
                        best_dist_q <= 6'h3F;
                        best_idx_q  <= 4'd0;
                        state_q     <= SEARCH;
                    end
                end
                SEARCH: begin
                    best_dist_q <= best_dist_d;
                    best_idx_q  <= best_idx_d;
                    cnt_q       <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        if (rgb_q == KEY_COLOR) begin
                            out_index_q       <= TRANSPARENT_INDEX;
                            out_dist_q        <= 6'd0;
                            out_transparent_q <= 1'b1;
                        end else begin
                            out_index_q       <= best_idx_d;
                            out_dist_q        <= best_dist_d;
                            out_transparent_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready        = (state_q == IDLE) && !Reset;
    assign out_valid       = out_valid_q;
    assign out_index       = out_index_q;
    assign out_dist        = out_dist_q;
    assign out_transparent = out_transparent_q;

endmodule

// File: tb/tb_palette_color_encoder.sv
// Bench for palette_color_encoder: directed colours, backpressure, reset abort
// and a random stream, each compared against a scoreboard of expected results.
module tb_palette_color_encoder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_rgb = 12'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_index;
    logic [5:0]  out_dist;
    logic        out_transparent;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [10:0] exp_q[$];

    logic [11:0] pal [16] = '{12'hE3F, 12'h222, 12'h7A7, 12'hE3F, 12'hE3F, 12'h000, 12'h464, 12'h110,
                              12'hE3F, 12'h343, 12'h686, 12'hE3F, 12'hE3F, 12'h575, 12'h111, 12'hE3F};

    palette_color_encoder dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_dist(out_dist), .out_transparent(out_transparent)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [10:0] model(input logic [11:0] c);
        int best;
        int bi;
        int d;
        logic [11:0] p;
        if (c == 12'hE3F) return {4'd0, 6'd0, 1'b1};
        best = 63;
        bi = 0;
        for (int i = 0; i < 16; i++) begin
            p = pal[i];
            if (p == 12'hE3F) continue;
            d = iabs(int'(c[11:8]) - int'(p[11:8])) + iabs(int'(c[7:4]) - int'(p[7:4]))
              + iabs(int'(c[3:0]) - int'(p[3:0]));
            if (d < best) begin
                best = d;
                bi = i;
            end
        end
        return {4'(bi), 6'(best), 1'b0};
    endfunction

    // Present a colour for one edge from IDLE and queue what it should produce.
    task automatic push_color(input logic [11:0] rgb, input logic [10:0] expv);
        in_rgb = rgb;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        exp_q.push_back(expv);
    endtask

    // Called in the cycle after acceptance; returns that cycle's offset from acceptance.
    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk);
            #1;
        end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++;
        if ({out_valid, out_index, out_dist, out_transparent} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=000", {out_valid, out_index, out_dist, out_transparent});
        end
        Reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_exact_hits();
        logic [11:0] c [3] = '{12'h7A7, 12'h000, 12'h111};
        logic [10:0] e [3] = '{{4'd2, 6'd0, 1'b0}, {4'd5, 6'd0, 1'b0}, {4'd14, 6'd0, 1'b0}};
        logic [10:0] expv;
        int lat;
        for (int i = 0; i < 3; i++) begin
            push_color(c[i], e[i]);
            wait_out(lat);
            total++;
            if (lat !== 17) begin bad++; $display("FAIL exact_latency rgb=%h got=%0d exp=17", c[i], lat); end
            expv = exp_q.pop_front();
            total++;
            if ({out_index, out_dist, out_transparent} !== expv) begin
                bad++;
                $display("FAIL exact_result rgb=%h got=%h exp=%h", c[i], {out_index, out_dist, out_transparent}, expv);
            end
            @(posedge Clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL exact_release got=%b%b exp=01", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_key_color();
        logic [11:0] c [2] = '{12'hE3F, 12'hF3F};
        logic [10:0] e [2] = '{{4'd0, 6'd0, 1'b1}, {4'd2, 6'd23, 1'b0}};
        logic [10:0] expv;
        int lat;
        for (int i = 0; i < 2; i++) begin
            push_color(c[i], e[i]);
            wait_out(lat);
            total++;
            if (lat !== 17) begin bad++; $display("FAIL key_latency rgb=%h got=%0d exp=17", c[i], lat); end
            expv = exp_q.pop_front();
            total++;
            if ({out_index, out_dist, out_transparent} !== expv) begin
                bad++;
                $display("FAIL key_result rgb=%h got=%h exp=%h", c[i], {out_index, out_dist, out_transparent}, expv);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_tie_break();
        logic [11:0] c [2] = '{12'h010, 12'h221};
        logic [10:0] e [2] = '{{4'd5, 6'd1, 1'b0}, {4'd1, 6'd1, 1'b0}};
        logic [10:0] expv;
        int lat;
        for (int i = 0; i < 2; i++) begin
            push_color(c[i], e[i]);
            wait_out(lat);
            expv = exp_q.pop_front();
            total++;
            if (lat !== 17 || {out_index, out_dist, out_transparent} !== expv) begin
                bad++;
                $display("FAIL tie_result rgb=%h got=%h lat=%0d exp=%h lat=17", c[i],
                         {out_index, out_dist, out_transparent}, lat, expv);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] expv;
        int lat;
        int seen;
        out_ready = 1'b0;
        push_color(12'h575, {4'd13, 6'd0, 1'b0});
        wait_out(lat);
        expv = exp_q.pop_front();
        total++;
        if (lat !== 17 || {out_index, out_dist, out_transparent} !== expv) begin
            bad++;
            $display("FAIL bp_result got=%h lat=%0d exp=%h lat=17", {out_index, out_dist, out_transparent}, lat, expv);
        end
        in_rgb = 12'h000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_index, out_dist, out_transparent} !== expv) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got=%b%b %h exp=10 %h", k, out_valid, in_ready,
                         {out_index, out_dist, out_transparent}, expv);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL bp_no_accept got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid_search();
        logic [10:0] expv;
        int lat;
        push_color(12'h464, {4'd6, 6'd0, 1'b0});
        for (int k = 0; k < 7; k++) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        void'(exp_q.pop_front());
        total++;
        if ({out_valid, out_index, out_dist, out_transparent} !== 12'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state got=%h rdy=%b exp=000 rdy=1",
                     {out_valid, out_index, out_dist, out_transparent}, in_ready);
        end
        push_color(12'h686, {4'd10, 6'd0, 1'b0});
        wait_out(lat);
        expv = exp_q.pop_front();
        total++;
        if (lat !== 17 || {out_index, out_dist, out_transparent} !== expv) begin
            bad++;
            $display("FAIL midreset_next got=%h lat=%0d exp=%h lat=17", {out_index, out_dist, out_transparent}, lat, expv);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [11:0] c;
        logic [10:0] expv;
        int lat;
        int prev_acc;
        for (int i = 0; i < 16; i++) begin
            c = 12'($urandom_range(0, 4095));
            if (i == 3) c = 12'hE3F;
            push_color(c, model(c));
            if (i > 0) begin
                total++;
                if (acc_cyc - prev_acc < 18) begin
                    bad++;
                    $display("FAIL b2b_interval i=%0d got=%0d exp>=18", i, acc_cyc - prev_acc);
                end
            end
            prev_acc = acc_cyc;
            wait_out(lat);
            expv = exp_q.pop_front();
            total++;
            if (lat !== 17 || {out_index, out_dist, out_transparent} !== expv) begin
                bad++;
                $display("FAIL b2b_result rgb=%h got=%h lat=%0d exp=%h lat=17", c,
                         {out_index, out_dist, out_transparent}, lat, expv);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_exact_hits();
        test_key_color();
        test_tie_break();
        test_backpressure();
        test_reset_mid_search();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
